uart_flow_buffer: RTL
=====================

UART_FLOW_BUFFER -- requirements
Module: uart_flow_buffer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, UART character width; DEPTH, default 4096, rx FIFO depth in characters (power of two, >=4); HIGH_WATER, default DEPTH*3/4, fill level that triggers XOFF; LOW_WATER, default DEPTH/4, fill level that triggers XON (LOW_WATER < HIGH_WATER); CNT_WIDTH, default 16, drop counter width.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 arstn  input  1  reset, asynchronous, active-low.
REQ-004 s_rx_tdata/s_rx_tvalid/s_rx_tready  in/in/out  DATA_WIDTH/1/1  received characters from the UART.
REQ-005 m_inp_tdata/m_inp_tvalid/m_inp_tready  out/out/in  DATA_WIDTH/1/1  buffered characters toward the processor input adapter.
REQ-006 s_out_tdata/s_out_tvalid/s_out_tready  in/in/out  DATA_WIDTH/1/1  processor output characters.
REQ-007 m_tx_tdata/m_tx_tvalid/m_tx_tready  out/out/in  DATA_WIDTH/1/1  characters to the UART transmitter.
REQ-008 rx_frame_error, rx_overrun_error  input  1 each  single-cycle UART error pulses.
REQ-009 flow_en  input  1  enables XON/XOFF software flow control.
REQ-010 rx_error  output  1  sticky error flag.
REQ-011 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 xoff_active  output  1  high while the host is held off (XOFF sent, XON not yet sent).
REQ-013 drop_count  output  CNT_WIDTH  count of characters dropped on overflow, saturating.

Function
REQ-014 s_rx_tready SHALL be constantly 1 out of reset; the UART is never back-pressured.
REQ-015 A valid rx character SHALL be written when fifo_level < DEPTH, or when fifo_level == DEPTH and an m_inp pop occurs in the same cycle; otherwise it SHALL be dropped, drop_count SHALL increment (saturating at all-ones), and rx_error SHALL set.
REQ-016 fifo_level SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-017 The FIFO SHALL be first-word-fall-through with a registered output: a character pushed into an empty FIFO in cycle N SHALL appear with m_inp_tvalid=1 in cycle N+2; sustained throughput SHALL be one character per cycle.
REQ-018 m_inp_tdata SHALL be held stable while m_inp_tvalid=1 and m_inp_tready=0.
REQ-019 The flow FSM SHALL have states XON_IDLE, XOFF_PEND, XOFF_HELD, XON_PEND, with these transitions: XON_IDLE->XOFF_PEND when flow_en && fifo_level>=HIGH_WATER; XOFF_PEND->XOFF_HELD on the m_tx handshake of XOFF; XOFF_HELD->XON_PEND when fifo_level<=LOW_WATER or flow_en=0; XON_PEND->XON_IDLE on the m_tx handshake of XON; XOFF_PEND->XON_IDLE when flow_en=0 before XOFF is issued.
REQ-020 XOFF is 0x13 and XON is 0x11, zero-extended to DATA_WIDTH.
REQ-021 The m_tx output SHALL be a single register stage; new data SHALL be loaded only when the stage is empty or is being accepted in that cycle, and it SHALL be held unchanged while m_tx_tvalid=1 and m_tx_tready=0.
REQ-022 When loading the m_tx stage, a pending control character (XOFF_PEND or XON_PEND) SHALL take priority over s_out; s_out_tready SHALL be 0 in that load cycle.
REQ-023 Processor output bytes SHALL pass through unmodified, including values 0x11 and 0x13.
REQ-024 xoff_active SHALL be 1 in XOFF_HELD and XON_PEND, and 0 otherwise.
REQ-025 rx_error SHALL set on rx_frame_error, rx_overrun_error, or an overflow drop, and SHALL clear only on reset.

Reset
REQ-026 While arstn=0: FIFO empty, fifo_level=0, m_inp_tvalid=0, m_tx_tvalid=0, s_out_tready=0, FSM=XON_IDLE, xoff_active=0, rx_error=0, drop_count=0.
REQ-027 A reset asserted mid-transfer SHALL discard FIFO contents and any pending control character; after release, s_rx_tready and s_out_tready SHALL assert on the first clock edge.

Structure
REQ-028 The XON/XOFF character constants and the flow-state enum typedef SHALL live in a shared package uart_pkg.
REQ-029 FIFO storage and pointers SHALL be a sub-module, bram_fifo (parameters DATA_WIDTH, DEPTH; inferred block RAM); the FSM, tx mux and counters SHALL stay in uart_flow_buffer.

Verification (DEPTH=16, HIGH_WATER=12, LOW_WATER=4)
REQ-030 Push 0xA5 into an empty FIFO at cycle 0 with m_inp_tready=1 -> m_inp_tvalid=1 and m_inp_tdata=0xA5 at cycle 2; fifo_level returns to 0.
REQ-031 flow_en=1, m_inp_tready=0, push 12 bytes -> m_tx emits 0x13 and xoff_active=1; pop 8 bytes -> m_tx emits 0x11 and xoff_active=0.
REQ-032 Push 18 bytes with m_inp_tready=0 -> fifo_level=16, drop_count=2, rx_error=1; popped data is exactly bytes 1-16 in order.
REQ-033 s_out streams 0x13 continuously with m_tx_tready toggling, and XOFF triggers mid-stream -> one extra 0x13 is inserted only at a stage-load boundary, no processor byte is lost or duplicated, and m_tx_tdata is stable under stall.
REQ-034 Single-cycle rx_frame_error pulse -> rx_error=1 persists; pulse arstn low -> all outputs at reset values and fifo_level=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART flow-control buffer.
package uart_pkg;

  // Software flow-control characters (8-bit, zero-extended at the point of use).
  localparam logic [7:0] XOFF_CHAR = 8'h13;
  localparam logic [7:0] XON_CHAR  = 8'h11;

  // Host flow-control state.
  typedef enum logic [1:0] {
    XON_IDLE  = 2'd0,
    XOFF_PEND = 2'd1,
    XOFF_HELD = 2'd2,
    XON_PEND  = 2'd3
  } flow_state_e;

  // A control character is owed to the transmitter in the two PEND states.
  function automatic logic is_pending(flow_state_e s);
    return (s == XOFF_PEND) || (s == XON_PEND);
  endfunction

endpackage

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO on an inferred block RAM. The RAM read port
// register doubles as the output register, so a word written in cycle N is
// visible in cycle N+2, and back-to-back pops stream at one word per cycle.
module bram_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4096
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           level_q, level_d;
  logic                  out_valid_q, out_valid_d;
  logic                  pop;
  logic                  rd_en;
  logic [AW:0]           unread;

  // Pointer, occupancy and output-valid next-state. A slot is only freed when
  // its word leaves the output register, so a write at full with a
  // simultaneous pop overwrites the slot whose copy already sits in the
  // output register.
  always_comb begin
    pop         = out_valid_q && rd_ready;
    unread      = level_q - {{AW{1'b0}}, out_valid_q};
    rd_en       = (unread != '0) && (!out_valid_q || pop);
    wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d     = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (!wr_en && pop) begin
      level_d = level_q - (AW+1)'(1);
    end
    out_valid_d = out_valid_q;
    if (rd_en) begin
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // RAM read port; holds its value while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      out_data_q <= mem[rd_ptr_q];
    end
  end

  assign rd_data  = out_data_q;
  assign rd_valid = out_valid_q;
  assign level    = level_q;

endmodule

// File: rtl/uart_flow_buffer.sv
// UART receive buffer with XON/XOFF host flow control and a transmit mux.
// All streams use valid/ready: a transfer happens on a rising edge where
// valid and ready are both 1; a source keeps valid and data steady until
// that transfer, and ready may depend combinationally on valid.
module uart_flow_buffer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4096,
  parameter int HIGH_WATER = DEPTH * 3 / 4,
  parameter int LOW_WATER  = DEPTH / 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic [DATA_WIDTH-1:0]    s_rx_tdata,
  input  logic                     s_rx_tvalid,
  output logic                     s_rx_tready,
  output logic [DATA_WIDTH-1:0]    m_inp_tdata,
  output logic                     m_inp_tvalid,
  input  logic                     m_inp_tready,
  input  logic [DATA_WIDTH-1:0]    s_out_tdata,
  input  logic                     s_out_tvalid,
  output logic                     s_out_tready,
  output logic [DATA_WIDTH-1:0]    m_tx_tdata,
  output logic                     m_tx_tvalid,
  input  logic                     m_tx_tready,
  input  logic                     rx_frame_error,
  input  logic                     rx_overrun_error,
  input  logic                     flow_en,
  output logic                     rx_error,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     xoff_active,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic [1:0]               dbg_flow_state
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] HIGH_L  = LW'(HIGH_WATER);
  localparam logic [LW-1:0] LOW_L   = LW'(LOW_WATER);

  logic                  run_q, run_d;
  flow_state_e           state_q, state_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_ctrl_q, tx_ctrl_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  rx_error_q, rx_error_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d;

  logic                  inp_pop;
  logic                  rx_fire;
  logic                  fifo_push;
  logic                  rx_drop;
  logic                  tx_accept;
  logic                  stage_free;
  logic                  ctrl_ack;
  logic                  ctrl_unsent;
  logic                  xoff_cancel;
  logic                  ctrl_load;
  logic                  out_fire;

  bram_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .arstn    (arstn),
    .wr_en    (fifo_push),
    .wr_data  (s_rx_tdata),
    .rd_data  (m_inp_tdata),
    .rd_valid (m_inp_tvalid),
    .rd_ready (m_inp_tready),
    .level    (fifo_level)
  );

  // Receive admission, drop accounting and the transmit stage handshake terms.
  always_comb begin
    inp_pop     = m_inp_tvalid && m_inp_tready;
    rx_fire     = s_rx_tvalid && run_q;
    fifo_push   = rx_fire && ((fifo_level < DEPTH_L) || inp_pop);
    rx_drop     = rx_fire && !fifo_push;
    drop_d      = drop_q;
    if (rx_drop && (drop_q != '1)) begin
      drop_d = drop_q + CNT_WIDTH'(1);
    end
    rx_error_d  = rx_error_q | rx_frame_error | rx_overrun_error | rx_drop;
    run_d       = 1'b1;

    tx_accept   = tx_valid_q && m_tx_tready;
    stage_free  = !tx_valid_q || m_tx_tready;
    // tx_ctrl_q marks that the stage holds the control character owed by
    // the current PEND state, so its acceptance is the PEND exit event.
    ctrl_ack    = tx_accept && tx_ctrl_q;
    ctrl_unsent = is_pending(state_q) && !tx_ctrl_q;
    xoff_cancel = (state_q == XOFF_PEND) && !flow_en && !tx_ctrl_q;
    ctrl_load   = run_q && stage_free && ctrl_unsent && !xoff_cancel;
    s_out_tready = run_q && stage_free && !ctrl_unsent;
    out_fire    = s_out_tvalid && s_out_tready;
  end

  // Flow-control state transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      XON_IDLE:  if (flow_en && (fifo_level >= HIGH_L)) state_d = XOFF_PEND;
      XOFF_PEND: begin
        if (xoff_cancel) begin
          state_d = XON_IDLE;
        end else if (ctrl_ack) begin
          state_d = XOFF_HELD;
        end
      end
      XOFF_HELD: if ((fifo_level <= LOW_L) || !flow_en) state_d = XON_PEND;
      XON_PEND:  if (ctrl_ack) state_d = XON_IDLE;
      default:   state_d = XON_IDLE;
    endcase
  end

  // Transmit stage load: a control character wins over processor data.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_ctrl_d  = tx_ctrl_q;
    tx_data_d  = tx_data_q;
    if (ctrl_load) begin
      tx_valid_d = 1'b1;
      tx_ctrl_d  = 1'b1;
      tx_data_d  = (state_q == XOFF_PEND) ? DATA_WIDTH'(XOFF_CHAR)
                                          : DATA_WIDTH'(XON_CHAR);
    end else if (out_fire) begin
      tx_valid_d = 1'b1;
      tx_ctrl_d  = 1'b0;
      tx_data_d  = s_out_tdata;
    end else if (tx_accept) begin
      tx_valid_d = 1'b0;
      tx_ctrl_d  = 1'b0;
    end
  end

  // Registered state, cleared asynchronously; reset drops any owed character.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      run_q      <= 1'b0;
      state_q    <= XON_IDLE;
      tx_valid_q <= 1'b0;
      tx_ctrl_q  <= 1'b0;
      tx_data_q  <= '0;
      rx_error_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      run_q      <= run_d;
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_ctrl_q  <= tx_ctrl_d;
      tx_data_q  <= tx_data_d;
      rx_error_q <= rx_error_d;
      drop_q     <= drop_d;
    end
  end

  assign s_rx_tready    = run_q;
  assign m_tx_tvalid    = tx_valid_q;
  assign m_tx_tdata     = tx_data_q;
  assign rx_error       = rx_error_q;
  assign drop_count     = drop_q;
  assign xoff_active    = (state_q == XOFF_HELD) || (state_q == XON_PEND);
  assign dbg_flow_state = state_q;

endmodule
